// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle between the processor control FSM
// (master) and the multicycle ALU (slave).
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             alu_op;
  logic [2:0]       func;
  logic [WIDTH-1:0] reg1;
  logic [WIDTH-1:0] reg2;
  logic [WIDTH-1:0] imm;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_result;
  logic             zero_flag;
  logic             negative_flag;
  logic             carry_flag;
  logic             overflow_flag;

  modport master (
    output start, alu_op, func, reg1, reg2, imm,
    input  busy, done, alu_result, zero_flag, negative_flag, carry_flag,
           overflow_flag
  );

  modport slave (
    input  start, alu_op, func, reg1, reg2, imm,
    output busy, done, alu_result, zero_flag, negative_flag, carry_flag,
           overflow_flag
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU: latches operands on start, runs single-cycle ops in one
// EXEC cycle or an iterative shift-add multiply over WIDTH cycles, then
// presents a registered result and flags with a one-cycle done pulse.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_multicycle_if.slave    bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  typedef enum logic [2:0] {
    F_AND = 3'b000,
    F_ADD = 3'b001,
    F_SUB = 3'b010,
    F_SLL = 3'b011,
    F_SRL = 3'b100,
    F_SRA = 3'b101,
    F_MUL = 3'b110,
    F_SLT = 3'b111
  } func_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  func_t            op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] exec_res;
  logic             exec_c;
  logic             exec_v;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   shamt;

  logic             wr_en;
  logic [WIDTH-1:0] wr_res;
  logic             wr_c;
  logic             wr_v;

  // Single-cycle datapath and one multiply step from the latched operands
  always_comb begin
    add_full = {1'b0, a_q} + {1'b0, b_q};
    sub_res  = a_q - b_q;
    shamt    = b_q[SHW-1:0];
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    case (op_q)
      F_AND: exec_res = a_q & b_q;
      F_ADD: begin
        exec_res = add_full[WIDTH-1:0];
        exec_c   = add_full[WIDTH];
        exec_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (add_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      F_SUB: begin
        exec_res = sub_res;
        exec_c   = (a_q < b_q);
        exec_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                   (sub_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      F_SLL: exec_res = a_q << shamt;
      F_SRL: exec_res = a_q >> shamt;
      F_SRA: exec_res = $signed(a_q) >>> shamt;
      F_SLT: exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: exec_res = '0;
    endcase
    mul_next = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);
  end

  // Next-state, operand latch, multiply iteration and result write
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    wr_res   = '0;
    wr_c     = 1'b0;
    wr_v     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.reg1;
          b_d     = bus.alu_op ? bus.imm : bus.reg2;
          op_d    = func_t'(bus.func);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (func_t'(bus.func) == F_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        wr_en   = 1'b1;
        wr_res  = exec_res;
        wr_c    = exec_c;
        wr_v    = exec_v;
      end
      S_MUL: begin
        acc_d = mul_next;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          wr_en   = 1'b1;
          wr_res  = mul_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (wr_en) begin
      result_d = wr_res;
      zero_d   = (wr_res == '0);
      neg_d    = wr_res[WIDTH-1];
      carry_d  = wr_c;
      ovf_d    = wr_v;
    end
  end

  // State, operand and result registers; reset aborts any operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= F_AND;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy          = (state_q == S_EXEC) || (state_q == S_MUL);
  assign bus.done          = (state_q == S_DONE);
  assign bus.alu_result    = result_q;
  assign bus.zero_flag     = zero_q;
  assign bus.negative_flag = neg_q;
  assign bus.carry_flag    = carry_q;
  assign bus.overflow_flag = ovf_q;
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, handshaked successor to the processor's single-cycle ALU.
- Generalised to WIDTH bits; adds arithmetic right shift, signed set-less-than and an iterative shift-add multiply.
- Adds correct carry and overflow flags.
- Sits between the register-file read stage and the write-back/branch logic of the multicycle processor. The control FSM issues `start` and waits for `done`.

Parameters:
- WIDTH, 32, datapath width in bits (≥ 4).
- SHW, $clog2(WIDTH), shift-amount bits taken from operand B. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- alu_op  input  1  operand-B select: 1 = imm, 0 = reg2.
- func  input  3  operation code.
- reg1  input  WIDTH  operand A.
- reg2  input  WIDTH  operand B when alu_op = 0.
- imm  input  WIDTH  operand B when alu_op = 1.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse: result/flags just updated.
- alu_result  output  WIDTH  registered result.
- zero_flag  output  1  result == 0.
- negative_flag  output  1  result[WIDTH-1].
- carry_flag  output  1  ADD carry-out / SUB borrow.
- overflow_flag  output  1  signed overflow for ADD/SUB.

Behaviour:
- Reset (async assert, sync deassert by clk): state = IDLE; busy, done, alu_result and all flags = 0. Applies mid-operation: the operation is aborted and the result is not written.
- Operand latch: on the edge where state = IDLE and start = 1:
  - A := reg1; B := alu_op ? imm : reg2; op := func.
  - Inputs may change afterwards without effect.
- func encoding:
  - 000 AND
  - 001 ADD
  - 010 SUB (A−B)
  - 011 SLL by B[SHW-1:0]
  - 100 SRL by B[SHW-1:0]
  - 101 SRA by B[SHW-1:0]
  - 110 MUL (low WIDTH bits of A*B, unsigned)
  - 111 SLT (signed A<B → 1, else 0)
- Shift amounts use only B[SHW-1:0]; upper B bits are ignored.
- States: IDLE, EXEC, MUL, DONE.
  - IDLE → EXEC on start (func ≠ 110).
  - IDLE → MUL on start (func = 110).
  - EXEC → DONE after 1 cycle.
  - MUL → DONE after WIDTH iterations.
  - DONE → IDLE unconditionally.
- MUL iteration: accumulator starts at 0. Iteration i adds (A << i) when B[i] = 1. An internal counter runs 0..WIDTH-1. The product wraps modulo 2^WIDTH.
- Result write: alu_result and all four flags are written on the edge entering DONE. done = 1 exactly for the DONE cycle. Flags hold their values between operations.
- Latency from the start-sampling edge to the done cycle:
  - 2 edges for single-cycle ops.
  - WIDTH+1 edges for MUL.
- busy = 1 in EXEC and MUL; 0 in IDLE and DONE.
- Back-to-back: start in the DONE cycle is ignored. The next start is accepted in IDLE, the cycle after done.
- start while busy: ignored, with no queueing.
- Flag rules:
  - zero = (result == 0); negative = result[WIDTH-1]; both apply for every op.
  - carry: ADD = carry-out of the WIDTH-bit add; SUB = 1 iff A < B unsigned (borrow); all other ops = 0.
  - overflow: ADD = A and B same sign and result sign differs; SUB = A and B signs differ and result sign ≠ A sign; all other ops = 0.

Test Plan:
- Reset mid-MUL: start MUL (A=3, B=5); assert reset_n=0 at cycle 10 → busy=0, done=0, alu_result=0 and all flags 0 immediately (asynchronously); no done pulse after release.
- ADD carry/zero (WIDTH=32): A=0xFFFFFFFF, reg2=1, alu_op=0 → done 2 edges after start; result=0, zero=1, carry=1, overflow=0, negative=0.
- SUB overflow: A=0x80000000, imm=1, alu_op=1 → result=0x7FFFFFFF, overflow=1, carry=0, negative=0. Then A=1, B=2 → result=0xFFFFFFFF, carry=1, negative=1.
- Shifts with masked amount: A=0x80000010, B=0x24 (low 5 bits = 4) →
  - SRL → 0x08000001
  - SRA → 0xF8000001
  - SLL → 0x00000100
- MUL latency/wrap: A=0x10000, B=0x10001 → done exactly 33 edges after start, busy high for 32 cycles; result=0x00010000 (wrapped), zero=0. Also A=7, B=6 → 42.
- Handshake: start held high continuously → ops accepted every 3rd cycle (single-cycle ops); starts during busy/DONE produce no extra done pulses; SLT A=−1, B=1 → result=1, all flags' carry/overflow = 0.
